test_port_writer: RTL and testbench
===================================

Name: test_port_writer

Overview:
- Bus-side stimulus generator for the end-of-run result test port; it is the writer that produces the traffic the testbed result checker consumes.
- Accepts result words over a valid/ready stream and buffers them in a small FIFO.
- Emits, as memory writes to the test-port address: the begin symbol, every buffered word, then the end symbol.
- Applies little-endian byte order and configurable write-hold / inter-write gap timing, emulating D-cache-stalled stores.

Parameters:
- TEST_PORT, 30'hFF: word address driven on addr during every test-port write.
- BEGIN_SYM, 32'h00000168: readable-format value of the first write of a session.
- END_SYM, 32'hFFFFFD5D: readable-format value of the last write of a session.
- HOLD_CYCLES, 2: cycles wen stays high per write; legal range 1..15.
- GAP_CYCLES, 1: cycles wen stays low after each write; legal range 1..15. Must be at least 1 so the checker sees a falling edge.
- FIFO_DEPTH, 4: result-word FIFO entries; power of 2, at least 2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle pulse that begins a session; sampled in IDLE and DONE only.
- in_valid, input, 1: in_data/in_last are valid.
- in_data, input, 32: result word in readable (big-endian) format.
- in_last, input, 1: marks the final result word of the session.
- in_ready, output, 1: FIFO can accept a word this cycle.
- addr, output, 30: bus word address.
- data, output, 32: bus write data, little-endian.
- wen, output, 1: bus write enable.
- busy, output, 1: high in every state except IDLE and DONE.
- done, output, 1: end-symbol write and its trailing gap have completed.
- words_sent, output, 16: number of result words written; excludes the begin and end symbols.

Behaviour:
- Reset (async, active-low):
  - state=IDLE; FIFO empty; last_seen=0.
  - Output values: wen=0, addr=0, data=0, busy=0, done=0, words_sent=0.
  - A reset mid-write drops wen in the same instant; no partial write is completed.
- Byte order: data = {w[7:0], w[15:8], w[23:16], w[31:24]} for the word w being written.
- Idle bus: whenever wen=0, addr=0 and data=0.
- FIFO:
  - Each entry holds {last, word}.
  - Push occurs when in_valid && in_ready. in_ready = !full && !last_seen.
  - Accepting an entry with last=1 sets last_seen; it clears on the next start.
  - Push and pop may occur in the same cycle. When full, in_ready=0 that cycle regardless of any pop (no bypass).
  - Pushes are allowed in IDLE, so the FIFO can be prefilled.
- FSM:
  - IDLE: on start, load word=BEGIN_SYM, go to WRITE.
  - WRITE: wen=1, addr=TEST_PORT, data=swap(word) for exactly HOLD_CYCLES cycles, then go to GAP.
  - GAP: wen=0 for exactly GAP_CYCLES cycles, then choose the next state from the write just completed:
    - completed END_SYM -> DONE.
    - completed a data word tagged last -> load END_SYM, go to WRITE.
    - otherwise -> FETCH.
  - FETCH:
    - FIFO non-empty: pop, load the word and its last tag, increment words_sent (saturating at 16'hFFFF), go to WRITE next cycle.
    - FIFO empty: stay in FETCH with wen=0, indefinitely.
  - DONE: done=1, bus idle. On start: clear done and words_sent, reset last_seen, go to WRITE with BEGIN_SYM. The FIFO is not flushed.
- Latency: start sampled at edge k -> wen first high in cycle k+1.
  - A prefilled word's write begins GAP_CYCLES+1 cycles after the previous write's wen falls (the +1 is the FETCH cycle).
- Empty session: if the first popped entry is the last one, the sequence is BEGIN, that word, END. The end symbol is never sent without a last-tagged word.
- start outside IDLE and DONE is ignored.

Test Plan:
- Checker-compatible sequence, defaults:
  - Stimulus: prefill 0,1,1,1,1,0 with last on the 6th word; pulse start.
  - Required: exactly 8 wen pulses of 2 cycles each, all with addr=0xFF.
  - Required data, in order: 0x68010000, 0x00000000, 0x01000000 x4, 0x00000000, 0x5DFDFFFF.
  - Required end state: done=1, words_sent=6.
- Timing:
  - Stimulus: start at edge 0, FIFO prefilled.
  - Required: wen high in cycles 1-2, low in 3 (GAP) and 4 (FETCH), high in 5-6.
  - Stimulus: HOLD_CYCLES=1, GAP_CYCLES=3.
  - Required: every wen pulse lasts 1 cycle, and consecutive pulses are separated by 4 low cycles.
- Starvation:
  - Stimulus: FIFO empty after the begin write; supply one word 20 cycles later.
  - Required: wen stays 0 and busy=1 throughout; the write starts 2 cycles after the push.
- Backpressure:
  - Stimulus: in_valid held high with start low.
  - Required: in_ready drops after 4 accepts; after last is accepted, in_ready stays 0 until the next start.
- Byte swap:
  - Stimulus: in_data=0x12345678.
  - Required: data=0x78563412 while wen=1.
- Reset:
  - Stimulus: assert rst mid-WRITE.
  - Required: wen=0 immediately; after release, all outputs are at reset values and start replays BEGIN first.

Source files
------------

// File: rtl/test_port_writer.sv
// Test-port stimulus writer: buffers result words from a valid/ready stream and
// replays them as begin symbol, data words, end symbol, little-endian, to TEST_PORT.
module test_port_writer #(
  parameter logic [29:0] TEST_PORT   = 30'hFF,
  parameter logic [31:0] BEGIN_SYM   = 32'h00000168,
  parameter logic [31:0] END_SYM     = 32'hFFFFFD5D,
  parameter int          HOLD_CYCLES = 2,
  parameter int          GAP_CYCLES  = 1,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [29:0] addr,
  output logic [31:0] data,
  output logic        wen,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_sent
);
  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_FETCH,
    S_DONE
  } state_t;

  // FIFO entries are {last, word}; pointers carry a wrap bit to tell full from empty
  logic [32:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic [32:0] fifo_head;
  logic        last_seen_reg, last_seen_next;
  logic        start_take;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] word_reg, word_next;
  logic        tag_reg, tag_next;
  logic        end_reg, end_next;
  logic [15:0] sent_reg, sent_next;
  logic [31:0] word_swapped;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign in_ready   = !fifo_full && !last_seen_reg;
  assign push       = in_valid && in_ready;
  assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= {in_last, in_data};
  end

  // A start clears last_seen, but a last word accepted in the same cycle still sets it
  assign last_seen_next = (start_take ? 1'b0 : last_seen_reg) | (push & in_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      last_seen_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      last_seen_reg <= last_seen_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      word_reg  <= '0;
      tag_reg   <= 1'b0;
      end_reg   <= 1'b0;
      sent_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
      tag_reg   <= tag_next;
      end_reg   <= end_next;
      sent_reg  <= sent_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    word_next  = word_reg;
    tag_next   = tag_reg;
    end_next   = end_reg;
    sent_next  = sent_reg;
    pop        = 1'b0;
    start_take = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_take = 1'b1;
          state_next = S_WRITE;
          cnt_next   = '0;
          word_next  = BEGIN_SYM;
          tag_next   = 1'b0;
          end_next   = 1'b0;
          sent_next  = '0;
        end
      end
      S_WRITE: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = S_GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          if (end_reg) begin
            state_next = S_DONE;
          end else if (tag_reg) begin
            // the last-tagged data word goes straight to the end symbol, no fetch
            state_next = S_WRITE;
            word_next  = END_SYM;
            tag_next   = 1'b0;
            end_next   = 1'b1;
          end else begin
            state_next = S_FETCH;
          end
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          word_next  = fifo_head[31:0];
          tag_next   = fifo_head[32];
          end_next   = 1'b0;
          cnt_next   = '0;
          state_next = S_WRITE;
          if (sent_reg != 16'hFFFF) sent_next = sent_reg + 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Result words arrive big-endian; the bus takes them little-endian
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_swap
      assign word_swapped[8*gi +: 8] = word_reg[8*(3-gi) +: 8];
    end
  endgenerate

  assign wen        = (state_reg == S_WRITE);
  assign addr       = wen ? TEST_PORT : '0;
  assign data       = wen ? word_swapped : '0;
  assign busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done       = (state_reg == S_DONE);
  assign words_sent = sent_reg;
endmodule

// File: tb/tb_test_port_writer.sv
// Directed bench for test_port_writer: default-timing instance plus a HOLD=1/GAP=3 instance.
module tb_test_port_writer;
  logic        clk;
  logic        rst;
  logic        start, in_valid, in_last, in_ready, wen, busy, done;
  logic [31:0] in_data, data;
  logic [29:0] addr;
  logic [15:0] words_sent;
  logic        b_start, b_valid, b_last, b_ready, b_wen, b_busy, b_done;
  logic [31:0] b_din, b_dout;
  logic [29:0] b_addr;
  logic [15:0] b_words;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  test_port_writer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .addr(addr), .data(data), .wen(wen),
    .busy(busy), .done(done), .words_sent(words_sent)
  );

  test_port_writer #(.HOLD_CYCLES(1), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_data(b_din),
    .in_last(b_last), .in_ready(b_ready), .addr(b_addr), .data(b_dout), .wen(b_wen),
    .busy(b_busy), .done(b_done), .words_sent(b_words)
  );

  typedef struct {
    int          start;
    int          len;
    logic [31:0] data;
    logic [29:0] addr;
  } pulse_t;

  typedef struct {
    logic [31:0] din;
    logic        lst;
    logic [31:0] exp;
  } vec_t;

  pulse_t pq[$];
  pulse_t pqb[$];
  int     nvec = 0, nmis = 0;
  int     cyc = 0, idle_err = 0, unstable_err = 0;
  logic   wen_prev = 1'b0, b_wen_prev = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Record every wen pulse of either instance; flag idle-bus or mid-pulse changes
  initial forever begin
    int idx;
    @(negedge clk);
    if (wen) begin
      if (!wen_prev) pq.push_back('{cyc, 1, data, addr});
      else begin
        idx = pq.size() - 1;
        pq[idx].len = pq[idx].len + 1;
        if (pq[idx].data !== data || pq[idx].addr !== addr) unstable_err++;
      end
    end else if (addr !== 30'd0 || data !== 32'd0) idle_err++;
    if (b_wen) begin
      if (!b_wen_prev) pqb.push_back('{cyc, 1, b_dout, b_addr});
      else begin
        idx = pqb.size() - 1;
        pqb[idx].len = pqb[idx].len + 1;
      end
    end else if (b_addr !== 30'd0 || b_dout !== 32'd0) idle_err++;
    wen_prev   = wen;
    b_wen_prev = b_wen;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic push_word(input logic [31:0] d, input logic l, output bit ok);
    bit acc;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 300; i++) begin
      acc = in_ready;
      @(negedge clk);
      if (acc) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("push_accept", ok, 1);
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int lim, input string name);
    int n = 0;
    while (!done && n < lim) begin @(negedge clk); n++; end
    chk(name, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  vec_t        tbl [6];
  logic [31:0] seq_a [8];
  logic [31:0] bp [4];
  int          s, p, acc, nbusy, nrdy, n;
  bit          ok;

  initial begin
    tbl[0] = '{32'd0, 1'b0, 32'h00000000};
    tbl[1] = '{32'd1, 1'b0, 32'h01000000};
    tbl[2] = '{32'd1, 1'b0, 32'h01000000};
    tbl[3] = '{32'd1, 1'b0, 32'h01000000};
    tbl[4] = '{32'd1, 1'b0, 32'h01000000};
    tbl[5] = '{32'd0, 1'b1, 32'h00000000};
    seq_a[0] = 32'h68010000;
    for (int i = 0; i < 6; i++) seq_a[i+1] = tbl[i].exp;
    seq_a[7] = 32'h5DFDFFFF;
    bp[0] = 32'h11223344; bp[1] = 32'h55667788; bp[2] = 32'h99AABBCC; bp[3] = 32'hDDEEFF00;

    rst = 1'b0; start = 0; in_valid = 0; in_data = 0; in_last = 0;
    b_start = 0; b_valid = 0; b_din = 0; b_last = 0;
    repeat (3) @(negedge clk);
    chk("rst_wen", wen, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", words_sent, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // Checker-compatible session: prefill until full, then feed the rest live
    pq.delete();
    for (int i = 0; i < 4; i++) push_word(tbl[i].din, tbl[i].lst, ok);
    chk("prefill_full_ready", in_ready, 0);
    pulse_start(s);
    push_word(tbl[4].din, tbl[4].lst, ok);
    push_word(tbl[5].din, tbl[5].lst, ok);
    wait_done(300, "a_done");
    chk("a_pulse_count", pq.size(), 8);
    if (pq.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("a_data%0d", i), pq[i].data, seq_a[i]);
        chk($sformatf("a_len%0d", i), pq[i].len, 2);
        chk($sformatf("a_addr%0d", i), pq[i].addr, 30'hFF);
      end
      chk("a_t_begin", pq[0].start - s, 0);
      chk("a_t_word0", pq[1].start - pq[0].start, 4);
    end
    chk("a_words", words_sent, 6);
    chk("a_busy_end", busy, 0);
    chk("a_ready_after_last", in_ready, 0);

    // Restart from DONE, starve the FIFO, then one last-tagged word
    pq.delete();
    pulse_start(s);
    chk("b_done_clr", done, 0);
    chk("b_words_clr", words_sent, 0);
    chk("b_busy", busy, 1);
    chk("b_ready_clr", in_ready, 1);
    chk("b_begin_data", data, 32'h68010000);
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) nbusy++;
    end
    chk("starve_busy", nbusy, 0);
    chk("starve_pulses", pq.size(), 1);
    push_word(32'h12345678, 1'b1, ok);
    p = cyc;
    wait_done(100, "b_done");
    chk("b_pulse_count", pq.size(), 3);
    if (pq.size() == 3) begin
      chk("starve_latency", pq[1].start - p, 1);
      chk("swap_data", pq[1].data, 32'h78563412);
      chk("b_end_data", pq[2].data, 32'h5DFDFFFF);
    end
    chk("b_words", words_sent, 1);

    // Reset in the middle of the begin write
    pulse_start(s);
    chk("c_wen_pre", wen, 1);
    #2 rst = 1'b0;
    #1;
    chk("c_rst_wen", wen, 0);
    chk("c_rst_addr", addr, 0);
    chk("c_rst_data", data, 0);
    chk("c_rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("c_post_wen", wen, 0);
    chk("c_post_busy", busy, 0);
    chk("c_post_done", done, 0);
    chk("c_post_words", words_sent, 0);
    chk("c_post_ready", in_ready, 1);

    // Backpressure in IDLE, then a session replaying BEGIN first
    pq.delete();
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = (acc < 4) ? bp[acc] : 32'd0;
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc, 4);
    chk("bp_ready_full", in_ready, 0);
    pulse_start(s);
    push_word(32'hCAFEF00D, 1'b1, ok);
    nrdy = 0; n = 0;
    while (!done && n < 200) begin
      if (in_ready) nrdy++;
      @(negedge clk);
      n++;
    end
    chk("bp_ready_held_low", nrdy, 0);
    chk("bp_done", done, 1);
    chk("bp_pulse_count", pq.size(), 7);
    if (pq.size() == 7) begin
      chk("bp_begin_first", pq[0].data, 32'h68010000);
      chk("bp_w0", pq[1].data, 32'h44332211);
      chk("bp_w1", pq[2].data, 32'h88776655);
      chk("bp_w2", pq[3].data, 32'hCCBBAA99);
      chk("bp_w3", pq[4].data, 32'h00FFEEDD);
      chk("bp_w4", pq[5].data, 32'h0DF0FECA);
      chk("bp_end", pq[6].data, 32'h5DFDFFFF);
    end
    chk("bp_words", words_sent, 5);
    chk("bp_ready_done", in_ready, 0);
    pulse_start(s);
    chk("bp_ready_restart", in_ready, 1);

    // HOLD=1 / GAP=3 timing on the second instance
    b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_din  = 32'hA0 + i;
      b_last = (i == 2);
      chk("tb_ready", b_ready, 1);
      @(negedge clk);
    end
    b_valid = 1'b0; b_last = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    s = cyc;
    n = 0;
    while (!b_done && n < 200) begin @(negedge clk); n++; end
    chk("tb_done", b_done, 1);
    chk("tb_pulse_count", pqb.size(), 5);
    if (pqb.size() == 5) begin
      chk("tb_t_begin", pqb[0].start - s, 0);
      for (int i = 0; i < 5; i++) chk($sformatf("tb_len%0d", i), pqb[i].len, 1);
      for (int i = 1; i < 4; i++) chk($sformatf("tb_sep%0d", i), pqb[i].start - pqb[i-1].start, 5);
      chk("tb_sep_end", pqb[4].start - pqb[3].start, 4);
      chk("tb_w0", pqb[1].data, 32'hA0000000);
    end
    chk("tb_words", b_words, 3);

    chk("idle_bus", idle_err, 0);
    chk("pulse_stable", unstable_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
